// File: rtl/nasti_rw_scheduler_pkg.sv
// nasti_rw_scheduler_pkg: shared widths, transaction structs, response codes and FSM states.
// Exports: C_NASTI_* widths, ar_trans/aw_trans/w_trans/b_trans, RESP_*, sched_state_e, make_b().
package nasti_rw_scheduler_pkg;

    localparam int C_NASTI_ID_WIDTH   = 9;
    localparam int C_NASTI_ADDR_WIDTH = 16;
    localparam int C_NASTI_DATA_WIDTH = 64;
    localparam int C_NASTI_USER_WIDTH = 1;
    localparam int C_NASTI_STRB_WIDTH = C_NASTI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_CMD, WR_CMD, WR_DATA, WR_RESP} sched_state_e;

    typedef struct packed {
        logic [C_NASTI_ID_WIDTH-1:0]   id;
        logic [C_NASTI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                    len;
        logic [2:0]                    size;
        logic [1:0]                    burst;
    } ar_trans;

    typedef struct packed {
        logic [C_NASTI_ID_WIDTH-1:0]   id;
        logic [C_NASTI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                    len;
        logic [2:0]                    size;
        logic [1:0]                    burst;
        logic [C_NASTI_USER_WIDTH-1:0] user;
    } aw_trans;

    typedef struct packed {
        logic [C_NASTI_DATA_WIDTH-1:0] data;
        logic [C_NASTI_STRB_WIDTH-1:0] strb;
        logic                          last;
    } w_trans;

    typedef struct packed {
        logic [C_NASTI_ID_WIDTH-1:0]   id;
        logic [1:0]                    resp;
        logic [C_NASTI_USER_WIDTH-1:0] user;
    } b_trans;

    function automatic b_trans make_b(logic [C_NASTI_ID_WIDTH-1:0] id, logic err,
                                      logic [C_NASTI_USER_WIDTH-1:0] user);
        return '{id: id, resp: err ? RESP_SLVERR : RESP_OKAY, user: user};
    endfunction

endpackage

// File: rtl/nasti_rw_scheduler_if.sv
// nasti_rw_scheduler_if: FIFO-side and backend-side signals of the read/write scheduler.
// master: the scheduler (pops AR/AW/W, pushes B, drives cmd/wd); slave: FIFOs plus DDR backend.
interface nasti_rw_scheduler_if;
    import nasti_rw_scheduler_pkg::*;

    ar_trans                       rdata_ar;
    logic                          rempty_ar;
    logic                          rinc_ar;
    aw_trans                       rdata_aw;
    logic                          rempty_aw;
    logic                          rinc_aw;
    w_trans                        rdata_w;
    logic                          rempty_w;
    logic                          rinc_w;
    b_trans                        wdata_b;
    logic                          wfull_b;
    logic                          winc_b;
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_write;
    logic [C_NASTI_ID_WIDTH-1:0]   cmd_id;
    logic [C_NASTI_ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]                    cmd_len;
    logic [2:0]                    cmd_size;
    logic [1:0]                    cmd_burst;
    logic                          wd_valid;
    logic                          wd_ready;
    logic [C_NASTI_DATA_WIDTH-1:0] wd_data;
    logic [C_NASTI_STRB_WIDTH-1:0] wd_strb;
    logic                          wd_last;

    modport master (
        input  rdata_ar, rempty_ar, rdata_aw, rempty_aw, rdata_w, rempty_w, wfull_b,
               cmd_ready, wd_ready,
        output rinc_ar, rinc_aw, rinc_w, wdata_b, winc_b, cmd_valid, cmd_write, cmd_id,
               cmd_addr, cmd_len, cmd_size, cmd_burst, wd_valid, wd_data, wd_strb, wd_last
    );

    modport slave (
        output rdata_ar, rempty_ar, rdata_aw, rempty_aw, rdata_w, rempty_w, wfull_b,
               cmd_ready, wd_ready,
        input  rinc_ar, rinc_aw, rinc_w, wdata_b, winc_b, cmd_valid, cmd_write, cmd_id,
               cmd_addr, cmd_len, cmd_size, cmd_burst, wd_valid, wd_data, wd_strb, wd_last
    );

endinterface

// File: rtl/nasti_rw_scheduler.sv
// nasti_rw_scheduler: arbitrates AR/AW bursts, issues one DDR command at a time, streams W, pushes B.
// Ports: core_clk, core_rst (sync, active-high); bus (master modport) carries the AR/AW/W/B FIFO
// ports and the cmd_*/wd_* backend handshakes.
module nasti_rw_scheduler
    import nasti_rw_scheduler_pkg::*;
#(
    parameter int C_RD_STREAK = 4
) (
    input  logic                 core_clk,
    input  logic                 core_rst,
    nasti_rw_scheduler_if.master bus
);

    localparam logic [3:0] STREAK_MAX = 4'(C_RD_STREAK);

    sched_state_e                  state_q, state_d;
    logic [3:0]                    streak_q, streak_d;
    logic [7:0]                    beat_q, beat_d;
    logic                          err_q, err_d;
    logic                          write_q, write_d;
    logic [C_NASTI_ID_WIDTH-1:0]   id_q, id_d;
    logic [C_NASTI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                    len_q, len_d;
    logic [2:0]                    size_q, size_d;
    logic [1:0]                    burst_q, burst_d;
    logic [C_NASTI_USER_WIDTH-1:0] user_q, user_d;

    logic live, aw_pending, rd_win, wr_win, wd_last_i, beat_fire;

    // Every strobe is masked during reset so nothing is popped or pushed in that cycle.
    assign live       = !core_rst;
    assign aw_pending = !bus.rempty_aw;
    // A pending write preempts reads once the streak limit is reached.
    assign rd_win     = !bus.rempty_ar && !(aw_pending && streak_q == STREAK_MAX);
    assign wr_win     = aw_pending && !rd_win;
    // Last beat comes from the captured length; the master's w.last only feeds the error flag.
    assign wd_last_i  = state_q == WR_DATA && beat_q == len_q;
    assign beat_fire  = bus.wd_valid && bus.wd_ready;

    assign bus.rinc_ar   = live && state_q == IDLE && rd_win;
    assign bus.rinc_aw   = live && state_q == IDLE && wr_win;
    assign bus.cmd_valid = live && (state_q == RD_CMD || state_q == WR_CMD);
    assign bus.cmd_write = write_q;
    assign bus.cmd_id    = id_q;
    assign bus.cmd_addr  = addr_q;
    assign bus.cmd_len   = len_q;
    assign bus.cmd_size  = size_q;
    assign bus.cmd_burst = burst_q;
    assign bus.wd_valid  = live && state_q == WR_DATA && !bus.rempty_w;
    assign bus.wd_data   = state_q == WR_DATA ? bus.rdata_w.data : '0;
    assign bus.wd_strb   = state_q == WR_DATA ? bus.rdata_w.strb : '0;
    assign bus.wd_last   = live && wd_last_i;
    assign bus.rinc_w    = beat_fire;
    assign bus.winc_b    = live && state_q == WR_RESP && !bus.wfull_b;
    assign bus.wdata_b   = state_q == WR_RESP ? make_b(id_q, err_q, user_q) : '0;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        beat_d   = beat_q;
        err_d    = err_q;
        write_d  = write_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        user_d   = user_q;
        case (state_q)
            IDLE: begin
                if (rd_win) begin
                    state_d  = RD_CMD;
                    write_d  = 1'b0;
                    id_d     = bus.rdata_ar.id;
                    addr_d   = bus.rdata_ar.addr;
                    len_d    = bus.rdata_ar.len;
                    size_d   = bus.rdata_ar.size;
                    burst_d  = bus.rdata_ar.burst;
                    // rd_win with AW pending implies streak_q < STREAK_MAX, so this saturates.
                    streak_d = aw_pending ? streak_q + 4'd1 : 4'd0;
                end else if (wr_win) begin
                    state_d  = WR_CMD;
                    write_d  = 1'b1;
                    id_d     = bus.rdata_aw.id;
                    addr_d   = bus.rdata_aw.addr;
                    len_d    = bus.rdata_aw.len;
                    size_d   = bus.rdata_aw.size;
                    burst_d  = bus.rdata_aw.burst;
                    user_d   = bus.rdata_aw.user;
                    streak_d = 4'd0;
                end
            end
            RD_CMD:  state_d = bus.cmd_ready ? IDLE : RD_CMD;
            WR_CMD: begin
                if (bus.cmd_ready) begin
                    state_d = WR_DATA;
                    beat_d  = 8'd0;
                    err_d   = 1'b0;
                end
            end
            WR_DATA: begin
                if (beat_fire) begin
                    // Hold at the final count so len=255 never wraps.
                    beat_d  = wd_last_i ? beat_q : beat_q + 8'd1;
                    err_d   = err_q | (bus.rdata_w.last != wd_last_i);
                    state_d = wd_last_i ? WR_RESP : WR_DATA;
                end
            end
            WR_RESP: state_d = bus.wfull_b ? WR_RESP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            user_q   <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            write_q  <= write_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            user_q   <= user_d;
        end
    end

endmodule

// File: tb/tb_nasti_rw_scheduler.sv
// tb_nasti_rw_scheduler: directed bench with a transaction-level model of grant order, beats and B.
module tb_nasti_rw_scheduler;
    import nasti_rw_scheduler_pkg::*;

    localparam int RD_STREAK = 4;

    typedef struct packed {
        logic        write;
        logic [8:0]  id;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } cmd_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    always #5 core_clk = ~core_clk;

    nasti_rw_scheduler_if bus();

    nasti_rw_scheduler #(.C_RD_STREAK(RD_STREAK)) dut (
        .core_clk(core_clk),
        .core_rst(core_rst),
        .bus     (bus.master)
    );

    ar_trans q_ar[$], m_ar[$];
    aw_trans q_aw[$], m_aw[$];
    w_trans  q_w[$],  m_w[$];
    cmd_t    exp_cmd[$];
    beat_t   exp_beat[$];
    b_trans  exp_b[$];

    int     n_checks = 0;
    int     n_fail = 0;
    int     m_streak = 0;
    int     rinc_w_cnt = 0;
    int     beats_seen = 0;
    string  order = "";
    b_trans last_b = '0;
    logic   pop_ar = 0, pop_aw = 0, pop_w = 0;
    logic   wd_tog = 0;
    logic   prev_hold = 0, prev_gr_rd = 0, prev_gr_wr = 0, rst_prev = 0;
    cmd_t   prev_cmd = '0, cur;

    task automatic check(string name, logic [255:0] got, logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Compare process: checks every handshake against the model and the per-cycle rules.
    always @(negedge core_clk) begin
        cur = {bus.cmd_write, bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst};
        pop_ar = 0;
        pop_aw = 0;
        pop_w  = 0;
        if (core_rst) begin
            check("strobes in reset", 256'({bus.rinc_ar, bus.rinc_aw, bus.rinc_w, bus.winc_b,
                  bus.cmd_valid, bus.wd_valid}), 256'(0));
            prev_hold  = 0;
            prev_gr_rd = 0;
            prev_gr_wr = 0;
        end else begin
            if (rst_prev)
                check("outputs after reset", 256'({bus.rinc_ar, bus.rinc_aw, bus.rinc_w,
                      bus.winc_b, bus.wdata_b, bus.cmd_valid, cur, bus.wd_valid, bus.wd_data,
                      bus.wd_strb, bus.wd_last}), 256'(0));
            if (prev_gr_rd || prev_gr_wr)
                check("grant to cmd_valid", 256'({bus.cmd_valid, bus.cmd_write}),
                      256'({1'b1, prev_gr_wr}));
            if (prev_hold) check("cmd stable while stalled", 256'(cur), 256'(prev_cmd));
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (exp_cmd.size() == 0) fail("unexpected command");
                else begin
                    check("command", 256'(cur), 256'(exp_cmd.pop_front()));
                    order = {order, bus.cmd_write ? "W" : "R"};
                end
            end
            if (bus.rinc_ar && bus.rinc_aw) fail("both AR and AW popped");
            if (bus.wd_valid || bus.rinc_w)
                check("rinc_w handshake", 256'(bus.rinc_w), 256'(bus.wd_valid && bus.wd_ready));
            if (bus.wd_valid && bus.wd_ready) begin
                beats_seen++;
                if (exp_beat.size() == 0) fail("unexpected write beat");
                else check("write beat", 256'({bus.wd_data, bus.wd_strb, bus.wd_last}),
                           256'(exp_beat.pop_front()));
            end
            if (bus.rinc_w) rinc_w_cnt++;
            if (bus.winc_b) begin
                check("B push while full", 256'(bus.wfull_b), 256'(0));
                last_b = bus.wdata_b;
                if (exp_b.size() == 0) fail("unexpected B push");
                else check("B response", 256'(bus.wdata_b), 256'(exp_b.pop_front()));
            end
            prev_hold  = bus.cmd_valid && !bus.cmd_ready;
            prev_cmd   = cur;
            prev_gr_rd = bus.rinc_ar;
            prev_gr_wr = bus.rinc_aw;
            pop_ar = bus.rinc_ar;
            pop_aw = bus.rinc_aw;
            pop_w  = bus.rinc_w;
        end
        rst_prev = core_rst;
    end

    task automatic refresh();
        bus.rempty_ar = q_ar.size() == 0;
        bus.rdata_ar  = q_ar.size() > 0 ? q_ar[0] : '0;
        bus.rempty_aw = q_aw.size() == 0;
        bus.rdata_aw  = q_aw.size() > 0 ? q_aw[0] : '0;
        bus.rempty_w  = q_w.size() == 0;
        bus.rdata_w   = q_w.size() > 0 ? q_w[0] : '0;
    endtask

    // Advance one clock; the show-ahead FIFOs pop what the DUT requested in the cycle just ended.
    task automatic step();
        @(posedge core_clk);
        #1;
        if (pop_ar && q_ar.size() > 0) q_ar.delete(0);
        if (pop_aw && q_aw.size() > 0) q_aw.delete(0);
        if (pop_w && q_w.size() > 0) q_w.delete(0);
        if (wd_tog) bus.wd_ready = ~bus.wd_ready;
        refresh();
    endtask

    task automatic load_ar(logic [8:0] id, logic [15:0] addr, logic [7:0] len);
        ar_trans t;
        t = '{id: id, addr: addr, len: len, size: 3'd3, burst: 2'd1};
        q_ar.push_back(t);
        m_ar.push_back(t);
    endtask

    task automatic load_aw(logic [8:0] id, logic [15:0] addr, logic [7:0] len, logic user);
        aw_trans t;
        t = '{id: id, addr: addr, len: len, size: 3'd3, burst: 2'd1, user: user};
        q_aw.push_back(t);
        m_aw.push_back(t);
    endtask

    task automatic load_w(logic [63:0] data, logic [7:0] strb, logic last);
        w_trans t;
        t = '{data: data, strb: strb, last: last};
        q_w.push_back(t);
        m_w.push_back(t);
    endtask

    // Transaction-level model: replays the arbitration rule over everything loaded so far.
    task automatic plan();
        ar_trans a;
        aw_trans w;
        w_trans  b;
        logic    err;
        while (m_ar.size() > 0 || m_aw.size() > 0) begin
            if (m_ar.size() > 0 && !(m_aw.size() > 0 && m_streak == RD_STREAK)) begin
                a = m_ar.pop_front();
                exp_cmd.push_back(cmd_t'({1'b0, a.id, a.addr, a.len, a.size, a.burst}));
                m_streak = m_aw.size() > 0 ? m_streak + 1 : 0;
            end else begin
                w = m_aw.pop_front();
                exp_cmd.push_back(cmd_t'({1'b1, w.id, w.addr, w.len, w.size, w.burst}));
                m_streak = 0;
                err = 0;
                for (int k = 0; k <= int'(w.len); k++) begin
                    b = m_w.pop_front();
                    exp_beat.push_back(beat_t'({b.data, b.strb, k == int'(w.len)}));
                    err |= b.last != (k == int'(w.len));
                end
                exp_b.push_back('{id: w.id, resp: err ? RESP_SLVERR : RESP_OKAY, user: w.user});
            end
        end
    endtask

    task automatic drain(string name, int budget);
        int k;
        k = 0;
        while ((exp_cmd.size() > 0 || exp_beat.size() > 0 || exp_b.size() > 0) && k < budget) begin
            step();
            k++;
        end
        if (exp_cmd.size() > 0 || exp_beat.size() > 0 || exp_b.size() > 0) fail({name, " timeout"});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.cmd_ready = 1;
        bus.wd_ready  = 1;
        bus.wfull_b   = 0;
        refresh();
        repeat (3) step();
        core_rst = 0;
        step();

        // Single read, len 0.
        load_ar(9'd3, 16'h0100, 8'd0);
        refresh();
        plan();
        @(negedge core_clk);
        check("p1 rinc_ar", 256'(bus.rinc_ar), 256'(1));
        step();
        @(negedge core_clk);
        check("p1 cmd", 256'({bus.cmd_valid, bus.cmd_write, bus.cmd_addr}),
              256'({1'b1, 1'b0, 16'h0100}));
        step();
        @(negedge core_clk);
        check("p1 back to idle", 256'(bus.cmd_valid), 256'(0));
        drain("p1", 20);

        // Write len 3 with wd_ready toggling.
        rinc_w_cnt = 0;
        wd_tog = 1;
        load_aw(9'd5, 16'h2000, 8'd3, 1'b1);
        for (int i = 0; i < 4; i++) load_w(64'h1111_0000_0000_0000 + 64'(i), 8'hff, i == 3);
        refresh();
        plan();
        drain("p2", 200);
        wd_tog = 0;
        bus.wd_ready = 1;
        check("p2 rinc_w count", 256'(rinc_w_cnt), 256'(4));
        check("p2 B literal", 256'(last_b), 256'({9'd5, 2'b00, 1'b1}));

        // Read streak against one pending write.
        order = "";
        for (int i = 0; i < 10; i++) load_ar(9'(16 + i), 16'(i * 16), 8'(i));
        load_aw(9'd9, 16'h3000, 8'd0, 1'b0);
        load_w(64'hdead_beef_0000_0001, 8'h0f, 1'b1);
        refresh();
        plan();
        drain("p3", 300);
        n_checks++;
        if (order != "RRRRWRRRRRR") begin
            n_fail++;
            $display("FAIL p3 grant order: got %s expected RRRRWRRRRRR", order);
        end

        // Early w_last: two beats consumed, SLVERR.
        load_aw(9'd6, 16'h4000, 8'd1, 1'b0);
        load_w(64'haaaa_0000_0000_0000, 8'hff, 1'b1);
        load_w(64'hbbbb_0000_0000_0000, 8'hf0, 1'b0);
        refresh();
        plan();
        drain("p4", 100);
        check("p4 B literal", 256'(last_b), 256'({9'd6, 2'b10, 1'b0}));

        // Stalled command stays stable.
        bus.cmd_ready = 0;
        load_ar(9'd12, 16'h0abc, 8'd7);
        refresh();
        plan();
        repeat (4) step();
        bus.cmd_ready = 1;
        drain("p5", 20);

        // B FIFO full after the last beat; a new read waits behind it.
        bus.wfull_b = 1;
        load_aw(9'd7, 16'h5000, 8'd1, 1'b1);
        load_w(64'h0123_4567_89ab_cdef, 8'hff, 1'b0);
        load_w(64'hfedc_ba98_7654_3210, 8'hff, 1'b1);
        refresh();
        plan();
        k = 0;
        while (exp_beat.size() > 0 && k < 50) begin
            step();
            k++;
        end
        if (exp_beat.size() > 0) fail("p6 beats timeout");
        load_ar(9'd1, 16'h0040, 8'd0);
        refresh();
        plan();
        repeat (5) begin
            @(negedge core_clk);
            check("p6 winc_b held", 256'({bus.winc_b, bus.rinc_ar}), 256'(0));
            check("p6 wdata_b stable", 256'(bus.wdata_b), 256'({9'd7, 2'b00, 1'b1}));
            step();
        end
        bus.wfull_b = 0;
        @(negedge core_clk);
        check("p6 push on release", 256'(bus.winc_b), 256'(1));
        drain("p6", 20);

        // len 255.
        load_aw(9'd8, 16'h0000, 8'd255, 1'b1);
        for (int i = 0; i < 256; i++) load_w({$urandom, $urandom}, 8'($urandom), i == 255);
        refresh();
        plan();
        drain("p7", 600);
        check("p7 B literal", 256'(last_b), 256'({9'd8, 2'b00, 1'b1}));

        // Reset after 2 of 4 beats.
        load_aw(9'd2, 16'h0500, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) load_w(64'(i + 100), 8'hff, i == 3);
        refresh();
        plan();
        beats_seen = 0;
        k = 0;
        while (beats_seen < 2 && k < 50) begin
            step();
            k++;
        end
        if (beats_seen < 2) fail("p8 beats timeout");
        core_rst = 1;
        exp_cmd.delete();
        exp_beat.delete();
        exp_b.delete();
        m_streak = 0;
        step();
        core_rst = 0;
        repeat (4) begin
            @(negedge core_clk);
            check("p8 idle after reset", 256'({bus.wd_valid, bus.rinc_w, bus.winc_b, bus.cmd_valid}),
                  256'(0));
            step();
        end
        check("p8 W beats left", 256'(q_w.size()), 256'(2));
        q_w.delete();
        refresh();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
